// File: rtl/nrx_psg_ctrl.sv
// New Rally-X sound register file, voice decode and shared wave-ROM server.
// Define NRX_PSG_READBACK_EN to build the registered cpu_rdata readback path.
module nrx_psg_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_addr,
  input  logic [3:0]  cpu_wdata,
  output logic [3:0]  cpu_rdata,
  input  logic        snd_on,
  output logic [19:0] freq0,
  output logic [19:0] freq1,
  output logic [19:0] freq2,
  output logic [3:0]  vol0,
  output logic [3:0]  vol1,
  output logic [3:0]  vol2,
  output logic [2:0]  vn0,
  output logic [2:0]  vn1,
  output logic [2:0]  vn2,
  input  logic [7:0]  waveaddr0,
  input  logic [7:0]  waveaddr1,
  input  logic [7:0]  waveaddr2,
  output logic [3:0]  wavedata0,
  output logic [3:0]  wavedata1,
  output logic [3:0]  wavedata2,
  output logic [7:0]  rom_addr,
  input  logic [3:0]  rom_data
);

  typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} ph_t;

  ph_t              ph_r;
  logic [31:0][3:0] regs_r;
  logic [1:0]       tag_a_r;
  logic [1:0]       tag_b_r;
  logic             v_a_r;
  logic             v_b_r;
  logic [7:0]       sel_addr_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_r <= 128'h0;
    end else if (cpu_we) begin
      regs_r[cpu_addr] <= cpu_wdata;
    end
  end

  always_comb begin
    sel_addr_s = waveaddr0;
    case (ph_r)
      PH0:     sel_addr_s = waveaddr0;
      PH1:     sel_addr_s = waveaddr1;
      PH2:     sel_addr_s = waveaddr2;
      default: sel_addr_s = waveaddr0;
    endcase
  end

  // Three-stage fetch: address out (A), ROM registers it (B), capture to the tagged voice (C).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_r      <= PH0;
      rom_addr  <= 8'h00;
      tag_a_r   <= 2'd0;
      tag_b_r   <= 2'd0;
      v_a_r     <= 1'b0;
      v_b_r     <= 1'b0;
      wavedata0 <= 4'h0;
      wavedata1 <= 4'h0;
      wavedata2 <= 4'h0;
    end else begin
      rom_addr <= sel_addr_s;
      tag_a_r  <= ph_r;
      v_a_r    <= 1'b1;
      tag_b_r  <= tag_a_r;
      v_b_r    <= v_a_r;
      if (v_b_r) begin
        case (tag_b_r)
          2'd0:    wavedata0 <= rom_data;
          2'd1:    wavedata1 <= rom_data;
          2'd2:    wavedata2 <= rom_data;
          default: wavedata0 <= wavedata0;
        endcase
      end
      case (ph_r)
        PH0:     ph_r <= PH1;
        PH1:     ph_r <= PH2;
        PH2:     ph_r <= PH0;
        default: ph_r <= PH0;
      endcase
    end
  end

  assign vn0   = regs_r[5'h05][2:0];
  assign vn1   = regs_r[5'h0A][2:0];
  assign vn2   = regs_r[5'h0F][2:0];
  assign freq0 = {regs_r[5'h14], regs_r[5'h13], regs_r[5'h12], regs_r[5'h11], regs_r[5'h10]};
  assign freq1 = {regs_r[5'h19], regs_r[5'h18], regs_r[5'h17], regs_r[5'h16], 4'h0};
  assign freq2 = {regs_r[5'h1E], regs_r[5'h1D], regs_r[5'h1C], regs_r[5'h1B], 4'h0};
  assign vol0  = snd_on ? regs_r[5'h15] : 4'h0;
  assign vol1  = snd_on ? regs_r[5'h1A] : 4'h0;
  assign vol2  = snd_on ? regs_r[5'h1F] : 4'h0;

`ifdef NRX_PSG_READBACK_EN
  // Readback samples the pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rdata <= 4'h0;
    end else begin
      cpu_rdata <= regs_r[cpu_addr];
    end
  end
`else
  logic unused_regs_s;
  assign unused_regs_s = ^regs_r;
  assign cpu_rdata     = 4'h0;
`endif

endmodule

// File: tb/tb_nrx_psg_ctrl.sv
// Scoreboard bench for nrx_psg_ctrl: register decode, ROM server pipeline, reset gap, readback.
module tb_nrx_psg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [3:0]  cpu_wdata;
  logic [3:0]  cpu_rdata;
  logic        snd_on;
  logic [19:0] freq0, freq1, freq2;
  logic [3:0]  vol0, vol1, vol2;
  logic [2:0]  vn0, vn1, vn2;
  logic [7:0]  waveaddr0, waveaddr1, waveaddr2;
  logic [3:0]  wavedata0, wavedata1, wavedata2;
  logic [7:0]  rom_addr;
  logic [3:0]  rom_data;

  typedef struct {
    int         voice;
    logic [3:0] val;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   mph;

  nrx_psg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .snd_on(snd_on),
    .freq0(freq0), .freq1(freq1), .freq2(freq2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2),
    .vn0(vn0), .vn1(vn1), .vn2(vn2),
    .waveaddr0(waveaddr0), .waveaddr1(waveaddr1), .waveaddr2(waveaddr2),
    .wavedata0(wavedata0), .wavedata1(wavedata1), .wavedata2(wavedata2),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous wave ROM: returns the low nibble of the registered address.
  initial rom_data = 4'h0;
  always @(posedge clk) rom_data <= rom_addr[3:0];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] wd_of(input int v);
    case (v)
      0:       return wavedata0;
      1:       return wavedata1;
      default: return wavedata2;
    endcase
  endfunction

  // One clock: model the ROM server from the inputs seen at the edge, then retire due captures.
  task automatic tick();
    logic       rst_at;
    logic [7:0] samp;
    exp_t       e;
    rst_at = rst_n;
    samp   = (mph == 0) ? waveaddr0 : (mph == 1) ? waveaddr1 : waveaddr2;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_at) begin
      exp_q.delete();
      mph = 0;
    end else begin
      check_val($sformatf("rom_addr_ph%0d", mph), rom_addr, samp);
      e.voice = mph;
      e.val   = samp[3:0];
      e.due   = cyc + 2;
      exp_q.push_back(e);
      mph = (mph + 1) % 3;
    end
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_val($sformatf("wavedata%0d", e.voice), wd_of(e.voice), e.val);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_we    = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mph = 0;
    rst_n = 1'b0; cpu_we = 1'b0; cpu_addr = 5'h00; cpu_wdata = 4'h0; snd_on = 1'b1;
    waveaddr0 = 8'h12; waveaddr1 = 8'h34; waveaddr2 = 8'h56;
    tick();
    tick();
    check_val("rst_freq", {freq0 | freq1 | freq2}, 32'h0);
    check_val("rst_vol", {vol0, vol1, vol2}, 32'h0);
    check_val("rst_vn", {vn0, vn1, vn2}, 32'h0);
    check_val("rst_wavedata", {wavedata0, wavedata1, wavedata2}, 32'h0);
    check_val("rst_rom_addr", rom_addr, 32'h0);
    check_val("rst_rdata", cpu_rdata, 32'h0);
    rst_n = 1'b1;

    // freq0 / vol0 decode and snd_on gating
    for (int i = 0; i < 5; i++) wr(5'(5'h10 + i), 4'(i + 1));
    wr(5'h15, 4'hA);
    check_val("freq0", freq0, 32'h54321);
    check_val("vol0_on", vol0, 32'hA);
    snd_on = 1'b0;
    #1;
    check_val("vol0_off", vol0, 32'h0);
    check_val("freq0_snd_off", freq0, 32'h54321);
    snd_on = 1'b1;
    #1;
    check_val("vol0_back", vol0, 32'hA);

    // freq1 / vn2 decode
    wr(5'h16, 4'hF); wr(5'h17, 4'hE); wr(5'h18, 4'hD); wr(5'h19, 4'hC);
    wr(5'h0F, 4'hE);
    check_val("freq1", freq1, 32'hCDEF0);
    check_val("vn2", vn2, 32'h6);
    check_val("freq2_untouched", freq2, 32'h0);
    wr(5'h1F, 4'h7); wr(5'h0A, 4'hB);
    check_val("vol2", vol2, 32'h7);
    check_val("vn1", vn1, 32'h3);

    // steady fetch with fixed addresses
    for (int i = 0; i < 9; i++) tick();
    check_val("wd0_hold", wavedata0, 32'h2);
    check_val("wd1_hold", wavedata1, 32'h4);
    check_val("wd2_hold", wavedata2, 32'h6);

    // addresses changing every clock, only PH-slot samples matter
    for (int i = 0; i < 24; i++) begin
      waveaddr0 = 8'($urandom_range(0, 255));
      waveaddr1 = 8'($urandom_range(0, 255));
      waveaddr2 = 8'($urandom_range(0, 255));
      tick();
    end

    // one-edge reset mid-stream, then the no-capture gap
    waveaddr0 = 8'h12; waveaddr1 = 8'h34; waveaddr2 = 8'h56;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("mid_rst_wavedata", {wavedata0, wavedata1, wavedata2}, 32'h0);
    check_val("mid_rst_freq0", freq0, 32'h0);
    tick();
    check_val("gap1_wd0", wavedata0, 32'h0);
    tick();
    check_val("gap2_wd0", wavedata0, 32'h0);
    tick();
    check_val("first_wd0", wavedata0, 32'h2);
    for (int i = 0; i < 6; i++) tick();

    // readback path
    wr(5'h07, 4'h9);
    cpu_addr = 5'h07;
    tick();
`ifdef NRX_PSG_READBACK_EN
    check_val("rd_07", cpu_rdata, 32'h9);
`else
    check_val("rd_07", cpu_rdata, 32'h0);
`endif
    wr(5'h07, 4'h3);
`ifdef NRX_PSG_READBACK_EN
    check_val("rd_same_cycle_old", cpu_rdata, 32'h9);
`else
    check_val("rd_same_cycle_old", cpu_rdata, 32'h0);
`endif
    tick();
`ifdef NRX_PSG_READBACK_EN
    check_val("rd_new", cpu_rdata, 32'h3);
`else
    check_val("rd_new", cpu_rdata, 32'h0);
`endif
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
